// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM state and port encodings for the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - combinational two-way round-robin pick
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_b,
  output logic grant_valid
);

  assign grant_valid = a_req | b_req;
  // On a tie the port that was not served last wins.
  assign grant_b     = b_req & (~a_req | (last_grant == PORT_A));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch (A) and load/store (B)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  a_we,
  input  logic                  b_we,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_ack,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  output logic                  mem_load,
  output logic                  mem_output_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  localparam logic [2:0] RL_CNT = 3'(READ_LATENCY);

  state_t state, state_next;
  logic   grant_b, grant_valid;
  logic   grantee, last_grant, lat_we;
  logic   [2:0] cnt;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (last_grant),
    .grant_b     (grant_b),
    .grant_valid (grant_valid)
  );

  assign sel_we    = grant_b ? b_we    : a_we;
  assign sel_addr  = grant_b ? b_addr  : a_addr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;
  assign busy      = (state != IDLE);

  // Strobes and acks decode straight from the state register so reset kills them at once.
  always_comb begin
    state_next    = state;
    mem_enable    = 1'b0;
    mem_load      = 1'b0;
    mem_output_en = 1'b0;
    a_ack         = 1'b0;
    b_ack         = 1'b0;
    case (state)
      IDLE: if (grant_valid) state_next = RUN;
      RUN: begin
        mem_enable    = 1'b1;
        mem_load      = lat_we;
        mem_output_en = ~lat_we;
        if (cnt == 3'd1) state_next = ACK;
      end
      ACK: begin
        a_ack      = (grantee == PORT_A);
        b_ack      = (grantee == PORT_B);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grantee     <= PORT_A;
      last_grant  <= PORT_B;
      lat_we      <= 1'b0;
      cnt         <= 3'd0;
      mem_address <= '0;
      mem_data_in <= '0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (grant_valid) begin
          grantee     <= grant_b;
          lat_we      <= sel_we;
          mem_address <= sel_addr;
          mem_data_in <= sel_wdata;
          cnt         <= sel_we ? 3'd1 : RL_CNT;
        end
        RUN: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            mem_address <= '0;
            mem_data_in <= '0;
            if (!lat_we) begin
              if (grantee == PORT_B) b_rdata <= mem_data_out;
              else                   a_rdata <= mem_data_out;
            end
          end
        end
        ACK: last_grant <= grantee;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int RL1 = 1;
  localparam int RL3 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_req = 0, b_req = 0, a_we = 0, b_we = 0;
  logic [15:0] a_addr = 0, b_addr = 0, a_wdata = 0, b_wdata = 0;
  logic        a_ack, b_ack, busy, m_enable, m_load, m_oe;
  logic [15:0] a_rdata, b_rdata, m_addr, m_din, m_dout;

  logic        a_req3 = 0, b_req3 = 0, a_we3 = 0, b_we3 = 0;
  logic [15:0] a_addr3 = 0, b_addr3 = 0, a_wdata3 = 0, b_wdata3 = 0;
  logic        a_ack3, b_ack3, busy3, m3_enable, m3_load, m3_oe;
  logic [15:0] a_rdata3, b_rdata3, m3_addr, m3_din, m3_dout;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(RL1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .b_req(b_req), .a_addr(a_addr), .b_addr(b_addr),
    .a_we(a_we), .b_we(b_we), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_address(m_addr), .mem_enable(m_enable), .mem_load(m_load),
    .mem_output_en(m_oe), .mem_data_in(m_din), .mem_data_out(m_dout),
    .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(RL3)) dut3 (
    .clk(clk), .reset(reset),
    .a_req(a_req3), .b_req(b_req3), .a_addr(a_addr3), .b_addr(b_addr3),
    .a_we(a_we3), .b_we(b_we3), .a_wdata(a_wdata3), .b_wdata(b_wdata3),
    .a_ack(a_ack3), .b_ack(b_ack3), .a_rdata(a_rdata3), .b_rdata(b_rdata3),
    .mem_address(m3_addr), .mem_enable(m3_enable), .mem_load(m3_load),
    .mem_output_en(m3_oe), .mem_data_in(m3_din), .mem_data_out(m3_dout),
    .busy(busy3)
  );

  // Memory models: data_out only becomes valid after the latency worth of enable cycles.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  int en_run1 = 0;
  int en_run3 = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 16'h0;
        mem3[i] <= 16'h0;
      end
      mem1[8'h40] <= 16'h1111;
      mem1[8'h50] <= 16'h2222;
      mem3[8'h20] <= 16'h1234;
    end else begin
      if (m_enable && m_load)   mem1[m_addr[7:0]]  <= m_din;
      if (m3_enable && m3_load) mem3[m3_addr[7:0]] <= m3_din;
    end
    en_run1 <= m_enable  ? en_run1 + 1 : 0;
    en_run3 <= m3_enable ? en_run3 + 1 : 0;
  end

  assign m_dout  = (m_enable && m_oe && en_run1 >= RL1 - 1)   ? mem1[m_addr[7:0]]  : 16'hDEAD;
  assign m3_dout = (m3_enable && m3_oe && en_run3 >= RL3 - 1) ? mem3[m3_addr[7:0]] : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_ack | b_ack) check("ack_overlap", 32'(a_ack & b_ack), 32'd0);
  end

  task automatic access1(input string tag, input logic port, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int exp_lat, input logic [15:0] exp_rdata);
    int   n;
    int   en_n;
    logic got;
    n = 0; en_n = 0; got = 1'b0;
    @(negedge clk);
    if (port == 1'b0) begin
      a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (m_enable) begin
        en_n++;
        check({tag, "_addr"}, 32'(m_addr), 32'(addr));
        check({tag, "_load"}, 32'(m_load), 32'(we));
        check({tag, "_oe"}, 32'(m_oe), 32'(!we));
        if (we) check({tag, "_din"}, 32'(m_din), 32'(wdata));
      end
      check({tag, "_other_ack"}, 32'(port ? a_ack : b_ack), 32'd0);
      got = port ? b_ack : a_ack;
    end
    if (port == 1'b0) a_req = 0; else b_req = 0;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_en_cycles"}, 32'(en_n), we ? 32'd1 : 32'(RL1));
    if (!we) check({tag, "_rdata"}, 32'(port ? b_rdata : a_rdata), 32'(exp_rdata));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, a_cyc, b_cyc, k, en, oe;
    logic got;
    int   seq_cyc [4];
    logic seq_port [4];
    int   exp_cyc [4];
    logic exp_port [4];
    exp_cyc[0] = 2;  exp_cyc[1] = 5;  exp_cyc[2] = 8;  exp_cyc[3] = 11;
    exp_port[0] = 0; exp_port[1] = 1; exp_port[2] = 0; exp_port[3] = 1;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_a_ack", 32'(a_ack), 0);
    check("rst_b_ack", 32'(b_ack), 0);
    check("rst_enable", 32'(m_enable), 0);
    check("rst_load", 32'(m_load), 0);
    check("rst_oe", 32'(m_oe), 0);
    check("rst_addr", 32'(m_addr), 0);
    check("rst_din", 32'(m_din), 0);
    check("rst_a_rdata", 32'(a_rdata), 0);
    check("rst_b_rdata", 32'(b_rdata), 0);
    mem_init = 0;
    reset = 0;

    access1("wr_a", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2, 16'h0);
    check("wr_a_mem", 32'(mem1[8'h10]), 32'h0000BEEF);
    access1("rd_a", 1'b0, 1'b0, 16'h0010, 16'h0, 2, 16'hBEEF);
    access1("wr_b", 1'b1, 1'b1, 16'h0080, 16'hA5A5, 2, 16'h0);
    access1("rd_b", 1'b1, 1'b0, 16'h0080, 16'h0, 2, 16'hA5A5);

    // Reset while a write is in RUN: strobes drop immediately, nothing acked or written.
    @(negedge clk);
    b_req = 1; b_we = 1; b_addr = 16'h0030; b_wdata = 16'h5555;
    @(negedge clk);
    check("rstrun_enable_before", 32'(m_enable), 1);
    #1 reset = 1; b_req = 0;
    #1;
    check("rstrun_enable", 32'(m_enable), 0);
    check("rstrun_load", 32'(m_load), 0);
    check("rstrun_busy", 32'(busy), 0);
    check("rstrun_a_rdata", 32'(a_rdata), 0);
    check("rstrun_b_rdata", 32'(b_rdata), 0);
    @(negedge clk);
    reset = 0;
    got = 0;
    repeat (4) begin
      @(negedge clk);
      got = got | b_ack | a_ack;
    end
    check("rstrun_no_ack", 32'(got), 0);
    check("rstrun_no_write", 32'(mem1[8'h30]), 0);

    // Both read at once after reset: A wins the tie, B follows one transaction later.
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 16'h0040;
    b_req = 1; b_we = 0; b_addr = 16'h0050;
    a_cyc = -1; b_cyc = -1; n = 0;
    while ((a_cyc < 0 || b_cyc < 0) && n < 20) begin
      @(negedge clk);
      n++;
      if (a_ack) begin a_cyc = n; a_req = 0; end
      if (b_ack) begin b_cyc = n; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    check("tie_a_cycle", 32'(a_cyc), 2);
    check("tie_b_cycle", 32'(b_cyc), 5);
    check("tie_a_rdata", 32'(a_rdata), 32'h1111);
    check("tie_b_rdata", 32'(b_rdata), 32'h2222);

    // Both hold req continuously: grants alternate, one ack every 3 cycles.
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 16'h0050;
    b_req = 1; b_we = 0; b_addr = 16'h0040;
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (a_ack || b_ack) begin
        seq_cyc[k] = n;
        seq_port[k] = b_ack;
        k++;
      end
    end
    a_req = 0; b_req = 0;
    check("rr_count", 32'(k), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_port_%0d", i), 32'(seq_port[i]), 32'(exp_port[i]));
      check($sformatf("rr_cycle_%0d", i), 32'(seq_cyc[i]), 32'(exp_cyc[i]));
    end
    check("rr_a_rdata", 32'(a_rdata), 32'h2222);
    check("rr_b_rdata", 32'(b_rdata), 32'h1111);

    // Request fields changed during RUN must not affect the latched access.
    @(negedge clk);
    b_req = 1; b_we = 1; b_addr = 16'h0060; b_wdata = 16'h7777;
    @(negedge clk);
    check("chg_wr_addr", 32'(m_addr), 32'h0060);
    check("chg_wr_din", 32'(m_din), 32'h7777);
    b_addr = 16'h0070; b_wdata = 16'h0BAD;
    @(negedge clk);
    check("chg_wr_ack", 32'(b_ack), 1);
    b_req = 0;
    @(negedge clk);
    check("chg_wr_mem_old", 32'(mem1[8'h60]), 32'h7777);
    check("chg_wr_mem_new", 32'(mem1[8'h70]), 0);
    b_req = 1; b_we = 0; b_addr = 16'h0050;
    @(negedge clk);
    b_addr = 16'h0040;
    @(negedge clk);
    check("chg_rd_ack", 32'(b_ack), 1);
    check("chg_rd_rdata", 32'(b_rdata), 32'h2222);
    b_req = 0;

    // Latency-3 instance: enable held three cycles, ack at cycle 4.
    @(negedge clk);
    b_req3 = 1; b_we3 = 0; b_addr3 = 16'h0020;
    n = 0; en = 0; oe = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (m3_enable) en++;
      if (m3_oe) oe++;
      check("rl3_a_ack", 32'(a_ack3), 0);
      got = b_ack3;
    end
    b_req3 = 0;
    check("rl3_lat", 32'(n), 4);
    check("rl3_enable_cycles", 32'(en), 3);
    check("rl3_oe_cycles", 32'(oe), 3);
    check("rl3_rdata", 32'(b_rdata3), 32'h1234);
    @(negedge clk);
    check("rl3_idle_busy", 32'(busy3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
